// File: rtl/cnn_stream_pkg.sv
// Shared types and geometry helpers for the 1-D CNN streaming blocks.
// WINDOW_PAD_EN selects SAME padding (zero-padded frame edges) instead of VALID windows.
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        eFILL   = 2'd0,
        eSTREAM = 2'd1,
        eFLUSH  = 2'd2
    } win_state_e;

    localparam int DEF_WORD_SIZE    = 16;
    localparam int DEF_KERNEL_WIDTH = 3;
    localparam int DEF_INPUT_LENGTH = 8;

    typedef logic [DEF_KERNEL_WIDTH-1:0][DEF_WORD_SIZE-1:0] window_t;

    // Zero words placed on each side of a frame for SAME padding.
    function automatic int pad_of(input int kernel_width);
        return (kernel_width - 1) / 2;
    endfunction

    // Accepted samples needed before the first window of a frame is complete.
    function automatic int fill_n_of(input int kernel_width);
`ifdef WINDOW_PAD_EN
        return kernel_width - pad_of(kernel_width);
`else
        return kernel_width;
`endif
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// Parallel-out shift register holding the sliding window; [0] is the oldest word.
module window_shift_reg #(
    parameter int WORD_SIZE    = 16,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   shift_en_i,
    input  logic                                   clear_i,
    input  logic [WORD_SIZE-1:0]                   din_i,
    output logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_o
);

    logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0] win_q;

    // NOTE: sequential state uses non-blocking assignments so every tap sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            win_q <= '0;
        end else if (shift_en_i) begin
            win_q <= {din_i, win_q[KERNEL_WIDTH-1:1]};
        end
    end

    assign window_o = win_q;

endmodule

// File: rtl/conv1d_window_buffer.sv
// Sliding-window buffer between a single-entry FIFO and the conv MAC stage.
// Optional SAME padding is compiled in with the WINDOW_PAD_EN macro.
module conv1d_window_buffer
    import cnn_stream_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int KERNEL_WIDTH = 3,
    parameter int INPUT_LENGTH = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   valid_i,
    input  logic [WORD_SIZE-1:0]                   data_i,
    output logic                                   ready_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_o,
    output logic                                   last_o
);

    localparam int FILL_N = fill_n_of(KERNEL_WIDTH);
    localparam int SW     = $clog2(INPUT_LENGTH + 1);
    localparam int FW     = $clog2(KERNEL_WIDTH + 1);
    localparam logic [SW-1:0] SAMP_MAX  = SW'(INPUT_LENGTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_N - 1);
`ifdef WINDOW_PAD_EN
    localparam int PAD = pad_of(KERNEL_WIDTH);
    localparam logic [FW-1:0] PAD_LAST = FW'(PAD - 1);
`endif

    win_state_e      state_q, state_d;
    logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [SW-1:0]   samp_cnt_q, samp_cnt_d, samp_inc;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
`ifdef WINDOW_PAD_EN
    logic [FW-1:0]   pad_cnt_q, pad_cnt_d;
    logic            slot_free;
`endif
    logic            ready, acc, oacc;
    logic            shift_en, clear_win;
    logic [WORD_SIZE-1:0] win_din;

    assign ready    = (state_q != eFLUSH) && (!valid_q || ready_i);
    assign acc      = valid_i && ready;
    assign oacc     = valid_q && ready_i;
    assign samp_inc = (samp_cnt_q == SAMP_MAX) ? samp_cnt_q : samp_cnt_q + 1'b1;
`ifdef WINDOW_PAD_EN
    assign slot_free = !valid_q || ready_i;
`endif

    // NOTE: a synchronous reset lives inside the clocked block and is just the highest-priority branch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= eFILL;
            fill_cnt_q <= '0;
            samp_cnt_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef WINDOW_PAD_EN
            pad_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
`ifdef WINDOW_PAD_EN
            pad_cnt_q  <= pad_cnt_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin : next_state
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        samp_cnt_d = samp_cnt_q;
        valid_d    = valid_q;
        last_d     = last_q;
`ifdef WINDOW_PAD_EN
        pad_cnt_d  = pad_cnt_q;
`endif
        case (state_q)
            eFILL: begin
                if (acc) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    samp_cnt_d = samp_inc;
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = eSTREAM;
                        valid_d = 1'b1;
                        last_d  = (samp_inc == SAMP_MAX);
                    end
                end
            end
            eSTREAM: begin
                if (last_q && oacc) begin
                    // Frame done; a sample popped this same cycle opens the next frame.
                    state_d    = eFILL;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    fill_cnt_d = acc ? FW'(1) : '0;
                    samp_cnt_d = acc ? SW'(1) : '0;
                end else if (acc) begin
                    valid_d    = 1'b1;
                    samp_cnt_d = samp_inc;
                    if (samp_inc == SAMP_MAX) begin
`ifdef WINDOW_PAD_EN
                        state_d = eFLUSH;
`else
                        last_d  = 1'b1;
`endif
                    end
                end else if (oacc) begin
                    valid_d = 1'b0;
                end
            end
`ifdef WINDOW_PAD_EN
            eFLUSH: begin
                if (last_q && oacc) begin
                    state_d    = eFILL;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    fill_cnt_d = '0;
                    samp_cnt_d = '0;
                    pad_cnt_d  = '0;
                end else if (slot_free) begin
                    valid_d   = 1'b1;
                    pad_cnt_d = pad_cnt_q + 1'b1;
                    last_d    = (pad_cnt_q == PAD_LAST);
                end
            end
`endif
            default: state_d = eFILL;
        endcase
    end

    always_comb begin : outputs
        shift_en  = acc;
        win_din   = data_i;
        clear_win = 1'b0;
`ifdef WINDOW_PAD_EN
        if (state_q == eFLUSH) begin
            if (last_q && oacc) begin
                clear_win = 1'b1;
            end else if (slot_free) begin
                shift_en = 1'b1;
                win_din  = '0;
            end
        end
`endif
    end

    window_shift_reg #(
        .WORD_SIZE   (WORD_SIZE),
        .KERNEL_WIDTH(KERNEL_WIDTH)
    ) u_shift (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .shift_en_i(shift_en),
        .clear_i   (clear_win),
        .din_i     (win_din),
        .window_o  (window_o)
    );

    assign ready_o = ready;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_conv1d_window_buffer.sv
// Self-checking bench for conv1d_window_buffer: directed vector table, hand sequences and a
// random-stimulus scoreboard driven by a frame-level window model.
module tb_conv1d_window_buffer;
    import cnn_stream_pkg::*;

    localparam int W = 16;
    localparam int K = 3;
    localparam int L = 8;
`ifdef WINDOW_PAD_EN
    localparam int PAD = (K - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int FILL_N = K - PAD;
    localparam int NWIN   = L - K + 1 + 2 * PAD;

    typedef struct {
        window_t w;
        logic    last;
    } exp_t;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        window_t      ew;
        logic         el;
        logic         er;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         valid_o;
    logic         ready_i;
    window_t      window_o;
    logic         last_o;

    always #5 clk_i = ~clk_i;

    conv1d_window_buffer #(
        .WORD_SIZE   (W),
        .KERNEL_WIDTH(K),
        .INPUT_LENGTH(L)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .window_o(window_o),
        .last_o  (last_o)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         exp_q[$];
    window_t      beats[$];
    logic [W-1:0] src_q[$];
    logic [W-1:0] fs[L];
    int           n_in;
    bit           model_flush;
    bit           exp_valid_next;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic window_t mk(input int a, input int b, input int c);
        window_t w;
        w[0] = 16'(a);
        w[1] = 16'(b);
        w[2] = 16'(c);
        return w;
    endfunction

    // Word at position p of the zero-padded frame.
    function automatic logic [W-1:0] pv(input int p);
        if (p >= PAD && p < PAD + L) return fs[p - PAD];
        return '0;
    endfunction

    // Frame-level reference: window j covers padded positions j..j+K-1 once its newest sample arrives.
    task automatic model_accept(input logic [W-1:0] d);
        fs[n_in] = d;
        n_in++;
        if (n_in >= FILL_N) begin
            int j_hi;
            j_hi = (n_in == L) ? NWIN - 1 : n_in - FILL_N;
            for (int j = n_in - FILL_N; j <= j_hi; j++) begin
                exp_t e;
                for (int i = 0; i < K; i++) e.w[i] = pv(j + i);
                e.last = (j == NWIN - 1);
                exp_q.push_back(e);
            end
            exp_valid_next = 1'b1;
        end
        if (n_in == L) begin
            model_flush = (PAD > 0);
            n_in = 0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        beats.delete();
        n_in = 0;
        model_flush = 1'b0;
        exp_valid_next = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_clear();
    endtask

    // One clock cycle with scoreboard checks; entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        if (exp_valid_next) check("window latency", 64'(valid_o), 64'(1));
        exp_valid_next = 1'b0;
        if (!valid_o) check("last without valid", 64'(last_o), 64'(0));
        check("ready_o", 64'(ready_o), 64'(!model_flush && (!valid_o || r)));
        if (valid_o) begin
            check("window pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                check("window", 64'(window_o), 64'(exp_q[0].w));
                check("last_o", 64'(last_o), 64'(exp_q[0].last));
                if (r) begin
                    beats.push_back(window_o);
                    if (exp_q[0].last) model_flush = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
        end
        acc = v && ready_o;
        if (acc) model_accept(d);
        @(negedge clk_i);
    endtask

    // Drain src_q through the DUT. vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 always ready, 1 random.
    task automatic run_src(input int vmode, input int rmode, input int budget);
        logic acc;
        int   cyc;
        cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            logic         v;
            logic         r;
            logic [W-1:0] d;
            v = (src_q.size() > 0) &&
                ((vmode == 0) || (vmode == 1 && cyc % 2 == 0) || (vmode == 2 && $urandom_range(0, 1) == 1));
            d = (src_q.size() > 0) ? src_q[0] : '0;
            r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(v, d, r, acc);
            if (acc) void'(src_q.pop_front());
            cyc++;
        end
        check("stream drained", 64'(src_q.size() == 0 && exp_q.size() == 0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[$];
        logic    acc;
        window_t w0;

        // Directed vectors: samples 1..8 with the consumer always ready, straight out of reset.
        for (int i = 0; i < L + 2 + PAD; i++) begin
            vec_t t;
            t.v  = (i < L);
            t.d  = 16'(i + 1);
            t.r  = 1'b1;
            t.ev = (i >= FILL_N && i <= L + PAD);
            for (int k = 0; k < K; k++) t.ew[k] = (i - 2 + k > L) ? '0 : 16'(i - 2 + k);
            t.el = (i == L + PAD);
            t.er = !(PAD > 0 && i >= L && i <= L + PAD);
            tbl.push_back(t);
        end

        do_reset();
        check("reset valid_o", 64'(valid_o), 64'(0));
        check("reset last_o", 64'(last_o), 64'(0));
        check("reset window_o", 64'(window_o), 64'(0));
        check("reset ready_o", 64'(ready_o), 64'(1));

        foreach (tbl[i]) begin
            valid_i = tbl[i].v;
            data_i  = tbl[i].d;
            ready_i = tbl[i].r;
            #1;
            check($sformatf("vec%0d valid_o", i), 64'(valid_o), 64'(tbl[i].ev));
            check($sformatf("vec%0d last_o", i), 64'(last_o), 64'(tbl[i].el));
            check($sformatf("vec%0d ready_o", i), 64'(ready_o), 64'(tbl[i].er));
            if (tbl[i].ev) check($sformatf("vec%0d window", i), 64'(window_o), 64'(tbl[i].ew));
            @(negedge clk_i);
        end

        // Backpressure with window {2,3,4} on the output.
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b1, acc);
        for (int s = 0; s < 4; s++) begin
            valid_i = 1'b1;
            data_i  = 16'd5;
            ready_i = 1'b0;
            #1;
            check("stall window", 64'(window_o), 64'(mk(2, 3, 4)));
            check("stall valid_o", 64'(valid_o), 64'(1));
            check("stall ready_o", 64'(ready_o), 64'(0));
            cycle(1'b1, 16'd5, 1'b0, acc);
            check("stall no pop", 64'(acc), 64'(0));
        end
        cycle(1'b1, 16'd5, 1'b1, acc);
        check("release pop", 64'(acc), 64'(1));
        check("release window", 64'(window_o), 64'(mk(3, 4, 5)));

        // Back-to-back frames: no window may straddle the frame boundary.
        do_reset();
        for (int i = 1; i <= L; i++) src_q.push_back(16'(i));
        for (int i = 11; i < 11 + L; i++) src_q.push_back(16'(i));
        run_src(0, 0, 200);
        check("b2b beat count", 64'(beats.size()), 64'(2 * NWIN));
        w0 = (PAD > 0) ? mk(0, 11, 12) : mk(11, 12, 13);
        if (beats.size() > NWIN) check("b2b frame2 first window", 64'(beats[NWIN]), 64'(w0));

        // Reset after the fifth sample drops the partial frame.
        do_reset();
        for (int i = 1; i <= 5; i++) src_q.push_back(16'(i));
        run_src(0, 0, 100);
        do_reset();
        check("midreset valid_o", 64'(valid_o), 64'(0));
        check("midreset window_o", 64'(window_o), 64'(0));
        check("midreset ready_o", 64'(ready_o), 64'(1));
        for (int i = 21; i < 21 + L; i++) src_q.push_back(16'(i));
        run_src(0, 0, 100);
        check("midreset beat count", 64'(beats.size()), 64'(NWIN));
        w0 = (PAD > 0) ? mk(0, 21, 22) : mk(21, 22, 23);
        if (beats.size() > 0) check("midreset first window", 64'(beats[0]), 64'(w0));

        // Bubbly input with random consumer stalls, then fully random handshakes.
        do_reset();
        for (int i = 0; i < 5 * L; i++) src_q.push_back(16'($urandom));
        run_src(1, 1, 2000);
        check("bubbly beat count", 64'(beats.size()), 64'(5 * NWIN));
        beats.delete();
        for (int i = 0; i < 6 * L; i++) src_q.push_back(16'($urandom));
        run_src(2, 1, 3000);
        check("random beat count", 64'(beats.size()), 64'(6 * NWIN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
